// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: pixel coordinates plus sync/blanking strobes.
// The generator drives it and the tile/font logic consumes it.
interface vga_sync_gen_if;
    logic       pixel_tick;
    logic [9:0] Qh;
    logic [9:0] Qv;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       fin_linea;
    logic       fin_cuadro;

    modport master (
        output pixel_tick, Qh, Qv,
        output hsync, vsync, video_on,
        output fin_linea, fin_cuadro
    );

    modport slave (
        input pixel_tick, Qh, Qv,
        input hsync, vsync, video_on,
        input fin_linea, fin_cuadro
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V counters and
// registered sync/blanking outputs aligned with the coordinates.
module vga_sync_gen #(
    parameter int DIV       = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic           reloj,
    input  logic           reset,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [9:0]    qh;
    logic [9:0]    qv;
    logic [9:0]    qh_next;
    logic [9:0]    qv_next;
    logic          h_wrap;
    logic          hsync_q;
    logic          vsync_q;
    logic          video_q;

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick   = (div_cnt == DIV_LAST);
    assign h_wrap = tick && (qh == H_LAST);

    always_comb begin
        qh_next = qh;
        qv_next = qv;
        if (tick) begin
            qh_next = h_wrap ? 10'd0 : qh + 10'd1;
            if (h_wrap) begin
                qv_next = (qv == V_LAST) ? 10'd0 : qv + 10'd1;
            end
        end
    end

    // Strobes are computed from the next coordinates so they change on
    // the very edge the counters do (zero skew against Qh/Qv).
    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            qh      <= '0;
            qv      <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b1;
        end else begin
            qh      <= qh_next;
            qv      <= qv_next;
            hsync_q <= (qh_next >= HS_BEG && qh_next < HS_END)
                     ? SYNC_POL : ~SYNC_POL;
            vsync_q <= (qv_next >= VS_BEG && qv_next < VS_END)
                     ? SYNC_POL : ~SYNC_POL;
            video_q <= (qh_next < H_VIS) && (qv_next < V_VIS);
        end
    end

    assign vga.pixel_tick = tick;
    assign vga.Qh         = qh;
    assign vga.Qv         = qv;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_q;
    assign vga.fin_linea  = h_wrap;
    assign vga.fin_cuadro = h_wrap && (qv == V_LAST);
endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 instance plus a shrunken
// raster instance, both checked every cycle against a timing model.
module tb_vga_sync_gen;
    typedef struct packed {
        logic       tick;
        logic [9:0] qh;
        logic [9:0] qv;
        logic       hs;
        logic       vs;
        logic       von;
        logic       fl;
        logic       fc;
    } exp_t;

    logic reloj = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;
    int   ca;
    int   cb;

    always #5 reloj = ~reloj;

    vga_sync_gen_if bus_a();
    vga_sync_gen_if bus_b();

    vga_sync_gen dut_a (
        .reloj (reloj),
        .reset (rst_a),
        .vga   (bus_a)
    );

    vga_sync_gen #(
        .DIV(3), .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .SYNC_POL(1'b1)
    ) dut_b (
        .reloj (reloj),
        .reset (rst_b),
        .vga   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 20)
                $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // c = number of reloj edges since reset release
    function automatic exp_t model(int c, int dv, int hv, int hf, int hs,
                                   int hb, int vv, int vf, int vs, int vb,
                                   bit pol);
        exp_t e;
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int n  = c / dv;
        int h  = n % ht;
        int v  = (n / ht) % vt;
        e.tick = ((c % dv) == dv - 1);
        e.qh   = 10'(h);
        e.qv   = 10'(v);
        e.hs   = (h >= hv + hf && h < hv + hf + hs) ? pol : !pol;
        e.vs   = (v >= vv + vf && v < vv + vf + vs) ? pol : !pol;
        e.von  = (h < hv) && (v < vv);
        e.fl   = e.tick && (h == ht - 1);
        e.fc   = e.fl && (v == vt - 1);
        return e;
    endfunction

    task automatic cmp(input string id, input exp_t g, input exp_t e);
        check({id, "_tick"}, g.tick, e.tick);
        check({id, "_qh"},   g.qh,   e.qh);
        check({id, "_qv"},   g.qv,   e.qv);
        check({id, "_hs"},   g.hs,   e.hs);
        check({id, "_vs"},   g.vs,   e.vs);
        check({id, "_von"},  g.von,  e.von);
        check({id, "_fl"},   g.fl,   e.fl);
        check({id, "_fc"},   g.fc,   e.fc);
    endtask

    function automatic exp_t grab_a();
        return {bus_a.pixel_tick, bus_a.Qh, bus_a.Qv, bus_a.hsync,
                bus_a.vsync, bus_a.video_on, bus_a.fin_linea,
                bus_a.fin_cuadro};
    endfunction

    function automatic exp_t grab_b();
        return {bus_b.pixel_tick, bus_b.Qh, bus_b.Qv, bus_b.hsync,
                bus_b.vsync, bus_b.video_on, bus_b.fin_linea,
                bus_b.fin_cuadro};
    endfunction

    always @(posedge reloj or negedge rst_a)
        if (!rst_a) ca <= 0;
        else        ca <= ca + 1;

    always @(posedge reloj or negedge rst_b)
        if (!rst_b) cb <= 0;
        else        cb <= cb + 1;

    always @(negedge reloj) begin
        cmp("a", grab_a(), model(ca, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        cmp("b", grab_b(), model(cb, 3, 20, 3, 4, 5, 10, 2, 2, 3, 1'b1));
    end

    task automatic wait_qh(input int t);
        int k = 0;
        while (bus_a.Qh != 10'(t) && k < 5000) begin
            @(negedge reloj);
            k++;
        end
        check("wait_qh", bus_a.Qh, t);
    endtask

    initial begin
        int nt;
        int nvs;
        int nfc;
        exp_t rv_a;
        exp_t rv_b;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rv_a = model(0, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        rv_b = model(0, 3, 20, 3, 4, 5, 10, 2, 2, 3, 1'b1);
        repeat (10) @(negedge reloj);
        check("rst_qh",    bus_a.Qh, 0);
        check("rst_qv",    bus_a.Qv, 0);
        check("rst_hsync", bus_a.hsync, 1);
        check("rst_vsync", bus_a.vsync, 1);
        check("rst_von",   bus_a.video_on, 1);
        check("rst_tick",  bus_a.pixel_tick, 0);
        rst_a = 1'b1;
        rst_b = 1'b1;

        nt = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge reloj);
            if (bus_a.pixel_tick) nt++;
            if (i == 3) check("tick_4th", bus_a.pixel_tick, 1);
            if (i == 4) check("qh_first", bus_a.Qh, 1);
        end
        check("tick_count", nt, 100);
        check("qh_400", bus_a.Qh, 100);

        wait_qh(639);
        check("von_639", bus_a.video_on, 1);
        wait_qh(640);
        check("von_640", bus_a.video_on, 0);
        wait_qh(655);
        check("hs_655", bus_a.hsync, 1);
        wait_qh(656);
        check("hs_656", bus_a.hsync, 0);
        wait_qh(751);
        check("hs_751", bus_a.hsync, 0);
        wait_qh(752);
        check("hs_752", bus_a.hsync, 1);

        nvs = 0;
        nfc = 0;
        for (int i = 0; i < 32 * 17 * 3; i++) begin
            @(negedge reloj);
            if (bus_b.vsync) nvs++;
            if (bus_b.fin_cuadro) nfc++;
        end
        check("b_vs_cycles", nvs, 2 * 32 * 3);
        check("b_frames", nfc, 1);

        repeat (6) begin
            int which;
            repeat ($urandom_range(1500, 20)) @(negedge reloj);
            which = $urandom_range(1, 0);
            @(posedge reloj);
            #2;
            if (which == 0) begin
                rst_a = 1'b0;
                #1 cmp("arst_a", grab_a(), rv_a);
            end else begin
                rst_b = 1'b0;
                #1 cmp("arst_b", grab_b(), rv_b);
            end
            repeat ($urandom_range(4, 1)) @(negedge reloj);
            rst_a = 1'b1;
            rst_b = 1'b1;
        end
        repeat (50) @(negedge reloj);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
